// File: rtl/sram_frame_reader.sv
// sram_frame_reader: fetches a stored frame over the SRAM mux B port and shifts it out as an SPI mode-0 slave.
// Optional SPI_HEADER_EN prepends the 0xA5,0x5A header to each session.
module sram_frame_reader #(
   parameter int ADDR_W      = 20,
   parameter int FRAME_WORDS = 76800,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_clk,
   input  logic              spi_select,
   output logic              spi_miso,
   output logic              rd_start_n,
   output logic              rd_rw,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [15:0]       rd_data,
   input  logic              rd_ready,
   output logic              bus_req,
   output logic              frame_done,
   output logic              underrun
);

`ifdef SPI_HEADER_EN
   localparam bit HEADER = 1'b1;
`else
   localparam bit HEADER = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DATA, FULL} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, sel_sync;
   logic                   sck_prev, sel_prev, sck_fall, sel_fall, sel_rise;
   logic                   active, run, live, drop, primed, is_data;
   logic                   capture, keep, load, take, starve;
   logic [15:0]            buf_q, shreg;
   logic [3:0]             bit_cnt;
   logic [ADDR_W-1:0]      word_idx;

   function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
      return (a == LAST) ? '0 : a + 1'b1;
   endfunction

   // synchronize SCK and select, keeping one extra sample for edge detection
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sck_sync <= '0;
         sel_sync <= '1;
         sck_prev <= 1'b0;
         sel_prev <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         sel_sync <= {sel_sync[SYNC_STAGES-2:0], spi_select};
         sck_prev <= sck_sync[SYNC_STAGES-1];
         sel_prev <= sel_sync[SYNC_STAGES-1];
      end

   assign sck_fall = sck_prev & ~sck_sync[SYNC_STAGES-1];
   assign sel_fall = sel_prev & ~sel_sync[SYNC_STAGES-1];
   assign sel_rise = ~sel_prev & sel_sync[SYNC_STAGES-1];
   assign run      = active & ~sel_rise;
   assign capture  = (state == WAIT_DATA) & rd_ready;
   assign load     = run & ((~HEADER & ~primed & (state == FULL)) | (primed & sck_fall & (bit_cnt == 4'd15)));
   assign take     = load & (state == FULL);
   assign starve   = load & (state != FULL);
   assign keep     = live & ~drop & ~starve & run;

   // session flag: set by select falling, cleared by select rising
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) active <= 1'b0;
      else active <= sel_fall ? 1'b1 : sel_rise ? 1'b0 : active;

   assign bus_req = active;
   assign rd_rw   = 1'b1;

   // fetch FSM state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;

   // fetch FSM next state; a capture that is stale or already skipped returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (run | sel_fall) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!rd_ready) state_nxt = WAIT_DATA;
         WAIT_DATA: if (rd_ready) state_nxt = keep ? FULL : IDLE;
         FULL:      if (take | ~run) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // fetch FSM outputs
   always_comb rd_start_n = (state != ISSUE);

   // address, prefetch buffer, and tags marking the in-flight fetch as current or skipped
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rd_addr <= '0;
         buf_q   <= '0;
         live    <= 1'b0;
         drop    <= 1'b0;
      end else begin
         rd_addr <= sel_fall ? '0 : (capture & live) ? inc(rd_addr) : rd_addr;
         buf_q   <= (capture & keep) ? rd_data : buf_q;
         live    <= (sel_fall | sel_rise) ? 1'b0 : (state == ISSUE) ? 1'b1 : live;
         drop    <= (sel_fall | sel_rise | capture) ? 1'b0 : starve ? 1'b1 : drop;
      end

   // output shifter: loads a word (or zeros on starvation) and advances on each SCK fall
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         primed   <= 1'b0;
         is_data  <= 1'b0;
         word_idx <= '0;
      end else if (sel_fall) begin
         shreg    <= HEADER ? 16'hA55A : 16'h0000;
         bit_cnt  <= '0;
         primed   <= HEADER;
         is_data  <= ~HEADER;
         word_idx <= '0;
      end else if (!run) begin
         shreg   <= '0;
         bit_cnt <= '0;
         primed  <= 1'b0;
      end else if (load) begin
         shreg    <= take ? buf_q : 16'h0000;
         bit_cnt  <= '0;
         primed   <= 1'b1;
         is_data  <= 1'b1;
         word_idx <= (primed & is_data) ? inc(word_idx) : '0;
      end else if (primed & sck_fall) begin
         shreg   <= {shreg[14:0], 1'b0};
         bit_cnt <= bit_cnt + 4'd1;
      end

   assign spi_miso = shreg[15];

   // end-of-frame pulse and sticky starvation flag
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         frame_done <= run & primed & is_data & sck_fall & (bit_cnt == 4'd15) & (word_idx == LAST);
         underrun   <= sel_fall ? 1'b0 : starve ? 1'b1 : underrun;
      end

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb_sram_frame_reader: directed bench with SPI master, SRAM controller model and byte-stream reference model.
module tb_sram_frame_reader;
   localparam int FW = 4;
`ifdef SPI_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic        clk = 1'b0, reset_n = 1'b0, spi_clk = 1'b0, spi_select = 1'b1;
   logic        spi_miso, rd_start_n, rd_rw, bus_req, frame_done, underrun, rd_ready;
   logic [19:0] rd_addr;
   logic [15:0] rd_data;
   logic [15:0] mem [FW];
   logic [7:0]  lit1 [4];
   logic [7:0]  rx [$];
   logic [19:0] issued [$];
   logic [19:0] a;
   logic        busy;
   int          lat;
   int          passed = 0, total = 0;
   int          stall_addr = -1, stall_cycles = 0, zero_slot = -1, fd_cnt = 0, base = 0, n0 = 0;

   always #5 clk = ~clk;

   sram_frame_reader #(.ADDR_W(20), .FRAME_WORDS(FW), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_select(spi_select), .spi_miso(spi_miso),
      .rd_start_n(rd_start_n), .rd_rw(rd_rw), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .bus_req(bus_req), .frame_done(frame_done), .underrun(underrun)
   );

   // SRAM controller: ready drops after a start, data returns after a latency (longer for the stalled address)
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rd_ready <= 1'b1;
         rd_data  <= '0;
         busy     <= 1'b0;
         lat      <= 0;
         a        <= '0;
      end else if (busy) begin
         if (lat <= 1) begin
            rd_ready <= 1'b1;
            rd_data  <= mem[a[1:0]];
            busy     <= 1'b0;
         end else lat <= lat - 1;
      end else if (!rd_start_n) begin
         busy     <= 1'b1;
         a        <= rd_addr;
         rd_ready <= 1'b0;
         lat      <= (int'(rd_addr) == stall_addr) ? stall_cycles : 3;
      end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // expected byte idx of a session: optional header, then word k of the frame (wrapping), zeroed slot if starved
   function automatic logic [7:0] exp_byte(input int idx);
      int w;
      logic [15:0] word;
      if (idx < 2 * HDR) return (idx == 0) ? 8'hA5 : 8'h5A;
      w = idx / 2 - HDR;
      word = (w == zero_slot) ? 16'h0000 : mem[w % FW];
      return (idx % 2 == 0) ? word[15:8] : word[7:0];
   endfunction

   // per-cycle invariants and event recording
   always @(negedge clk)
      if (reset_n) begin
         if (!rd_start_n) issued.push_back(rd_addr);
         if (frame_done) fd_cnt++;
         chk("rd_rw", rd_rw, 1);
         chk("start_outside_session", !rd_start_n && !bus_req, 0);
         chk("addr_range", rd_addr < FW, 1);
      end

   task automatic sck_bit(output logic b);
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      b = spi_miso;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic shift_bytes(input int first, input int n);
      logic [7:0] v;
      logic b;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 8; i++) begin
            sck_bit(b);
            v = {v[6:0], b};
         end
         rx.push_back(v);
         chk($sformatf("byte%0d", first + k), v, exp_byte(first + k));
      end
   endtask

   task automatic start_session();
      @(negedge clk);
      spi_select = 1'b0;
      rx.delete();
      base = issued.size();
      repeat (40) @(negedge clk);
   endtask

   task automatic end_session();
      repeat (10) @(negedge clk);
      spi_select = 1'b1;
      repeat (6) @(negedge clk);
      chk("bus_req_after_end", bus_req, 0);
   endtask

   task automatic chk_issued(input int n);
      chk("issue_count", issued.size() - base, n);
      for (int k = 0; k < n && base + k < issued.size(); k++)
         chk($sformatf("issue_addr%0d", k), issued[base + k], k % FW);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic b;
      mem = '{16'h1234, 16'hABCD, 16'h5A0F, 16'h00FF};
`ifdef SPI_HEADER_EN
      lit1 = '{8'hA5, 8'h5A, 8'h12, 8'h34};
`else
      lit1 = '{8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
      repeat (3) @(negedge clk);
      chk("rst_miso", spi_miso, 0);
      chk("rst_start_n", rd_start_n, 1);
      chk("rst_rw", rd_rw, 1);
      chk("rst_addr", rd_addr, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_underrun", underrun, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // two words out, then prefetch
      start_session();
      chk("t1_bus_req", bus_req, 1);
      shift_bytes(0, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t1_lit%0d", k), rx[k], lit1[k]);
      chk("t1_no_frame_done", fd_cnt, 0);
      chk("t1_underrun", underrun, 0);
      end_session();
      chk_issued(4 - HDR);

      // full frame plus wrap into word 0
      fd_cnt = 0;
      start_session();
      shift_bytes(0, 7 + 2 * HDR);
      chk("t2_fd_before_last", fd_cnt, 0);
      shift_bytes(7 + 2 * HDR, 1);
      repeat (6) @(negedge clk);
      chk("t2_fd_once", fd_cnt, 1);
      shift_bytes(8 + 2 * HDR, 2);
      repeat (6) @(negedge clk);
      chk("t2_fd_still_once", fd_cnt, 1);
      chk("t2_wrap_hi", rx[8 + 2 * HDR], 8'h12);
      chk("t2_wrap_lo", rx[9 + 2 * HDR], 8'h34);
      end_session();
      chk_issued(7);

      // word 1 starved: sent as zeros, word 2 still aligned
      zero_slot = 1;
      stall_addr = 1;
      stall_cycles = 200;
      start_session();
      shift_bytes(0, 6 + 2 * HDR);
      chk("t3_underrun", underrun, 1);
      chk("t3_zero_hi", rx[2 * HDR + 2], 8'h00);
      chk("t3_zero_lo", rx[2 * HDR + 3], 8'h00);
      chk("t3_word2_hi", rx[2 * HDR + 4], 8'h5A);
      end_session();
      chk_issued(5);
      chk("t3_underrun_sticky", underrun, 1);
      zero_slot = -1;

      // abort after 12 bits with word 0 still in flight
      stall_addr = 0;
      stall_cycles = 300;
      start_session();
      chk("t4_underrun_cleared", underrun, 0);
      chk("t4_inflight", rd_ready, 0);
      for (int i = 0; i < 12; i++) sck_bit(b);
      spi_select = 1'b1;
      n0 = issued.size();
      repeat (6) @(negedge clk);
      chk("t4_bus_req_off", bus_req, 0);
      for (int k = 0; k < 500 && !rd_ready; k++) @(negedge clk);
      chk("t4_inflight_done", rd_ready, 1);
      repeat (20) @(negedge clk);
      chk("t4_no_new_start", issued.size(), n0);
      stall_addr = -1;

      // restart at address 0, then reset while word 2 is in WAIT_DATA
      stall_addr = 2;
      stall_cycles = 300;
      start_session();
      shift_bytes(0, 2 + 2 * HDR);
      chk("t5_restart_hi", rx[2 * HDR], 8'h12);
      chk("t5_restart_lo", rx[2 * HDR + 1], 8'h34);
      chk("t5_first_issue", issued[base], 0);
      repeat (10) @(negedge clk);
      chk("t5_pre_addr", rd_addr, 2);
      chk("t5_pre_waiting", rd_ready, 0);
      chk("t5_pre_bus_req", bus_req, 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_miso", spi_miso, 0);
      chk("t5_rst_start_n", rd_start_n, 1);
      chk("t5_rst_rw", rd_rw, 1);
      chk("t5_rst_addr", rd_addr, 0);
      chk("t5_rst_bus_req", bus_req, 0);
      chk("t5_rst_frame_done", frame_done, 0);
      chk("t5_rst_underrun", underrun, 0);
      spi_select = 1'b1;
      stall_addr = -1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      n0 = issued.size();
      repeat (50) @(negedge clk);
      chk("t5_idle_bus_req", bus_req, 0);
      chk("t5_idle_no_start", issued.size(), n0);
      chk("t5_idle_addr", rd_addr, 0);
      chk("t5_idle_miso", spi_miso, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
